output_argmax: RTL and testbench
================================

# output_argmax

Classification back-end placed directly downstream of the network's output layer. It accepts one output vector of NO signed lane values per handshake and scans the lanes serially, one per cycle, to find the largest. It then presents the winning class index and its value on a valid/ready stream. An optional statistics path compares the index with a label stream and keeps hit and total counters for on-chip accuracy measurement.

## Interface
Parameters:
- NO, 7, number of output lanes (classes), ≥1
- NH1, 6, width of the last hidden layer; sets the lane width
- WV, 8, base value width
- WN, 16, statistics counter width
- Derived: WO = $clog2(NH1)+1+WV is the lane width; WC = max($clog2(NO),1) is the index width

Ports:
- iCLK  in  1  clock; all logic on its rising edge
- iRST  in  1  reset; synchronous, active-high
- iValid_AM_Output  in  1  input vector valid
- oReady_AM_Output  out  1  input vector ready
- iData_AM_Output  in  NO*WO  lanes; lane k occupies [k*WO +: WO], two's complement
- oValid_BM_Class  out  1  result valid
- iReady_BM_Class  in  1  result ready
- oData_BM_Class  out  WC  winning lane index
- oData_BM_Max  out  WO  winning lane value
- iValid_AS_Label / oReady_AS_Label / iData_AS_Label  in/out/in  1/1/WC  label stream (ARGMAX_STATS_EN only)
- oData_BM_Hit  out  1  index equals label (ARGMAX_STATS_EN only)
- iClear  in  1  synchronous counter clear (ARGMAX_STATS_EN only)
- oHitCount, oTotalCount  out  WN  statistics (ARGMAX_STATS_EN only)

## Operation
- FSM with three states: IDLE, SCAN and OUT. Reset state is IDLE.
- IDLE:
  - oReady_AM_Output is 1.
  - On handshake, capture the whole vector. Set max = lane 0, idx = 0, k = 1.
  - Go to SCAN, or directly to OUT if NO == 1.
- SCAN:
  - Each cycle, compare lane k (signed) against max.
  - If lane k > max, then max ← lane k and idx ← k. On ties the lowest index wins.
  - Increment k. After lane NO-1 is processed, go to OUT.
- OUT:
  - oValid_BM_Class is 1; oData_BM_Class = idx and oData_BM_Max = max, held stable.
  - On handshake, go to IDLE.
- No new input is accepted in SCAN or OUT. The captured vector is not affected by iData changes after acceptance.
- Result outputs keep their last value in IDLE and SCAN. They are 0 after reset.

## Timing
- Input handshake in cycle c gives SCAN in cycles c+1 … c+NO-1 and oValid_BM_Class = 1 from cycle c+NO.
- With iReady_BM_Class held at 1, throughput is one vector per NO+1 cycles.
- Output backpressure: OUT is held indefinitely and all outputs stay stable.
- Reset values:
  - oReady_AM_Output = 0 while iRST is high; 1 in the first cycle after release.
  - oValid_BM_Class = 0 and all data outputs = 0.
  - Counters = 0 and oReady_AS_Label = 0.
- Reset mid-SCAN or mid-OUT: the vector is dropped, no result is emitted, and the block returns to IDLE on the next edge.
- Valid must not depend combinationally on ready in either direction.

## Configuration
- Macro: ARGMAX_STATS_EN.
- Defined:
  - Label ports, iClear, oData_BM_Hit and both counters exist.
  - The IDLE handshake is joint: a vector is accepted only when iValid_AM_Output and iValid_AS_Label are both 1. oReady_AM_Output and oReady_AS_Label are asserted together and complete in the same cycle. The label is captured with the vector.
  - On the SCAN→OUT transition: oData_BM_Hit ← (idx == label), oTotalCount += 1, and oHitCount += hit. Both counters saturate at 2^WN-1.
  - iClear zeroes both counters. If iClear coincides with a counting transition, clear wins and the event is not counted. oData_BM_Hit is still produced.
- Undefined: these ports and registers are absent, and the input handshake uses the output stream alone.

## Test plan
- Argmax: NO=7, WO=12, lanes {5, -3, 40, 12, 40, -100, 0}, iReady held 1. Required: oData_BM_Class=2 and oData_BM_Max=40, with oValid rising exactly 7 cycles after the input handshake.
- All negative: lanes {-2048, -7, -1, -1, -300, -5, -2047}. Required: index 2, max -1 (signed compare and lowest-index tie rule).
- Backpressure: hold iReady_BM_Class=0 for 20 cycles. Required: oValid stays 1, data stays stable, oReady_AM_Output stays 0; the result is released 1 cycle after ready rises, and IDLE follows.
- Reset mid-scan: assert iRST at cycle c+3. Required: no oValid pulse and oReady_AM_Output=0 during reset. A new vector {0,0,0,0,0,0,9} then yields index 6.
- Stats (ARGMAX_STATS_EN): 4 vectors with winners {1,3,3,0} and labels {1,2,3,0}. Required: oData_BM_Hit sequence {1,0,1,1}, oHitCount=3, oTotalCount=4. An iClear coinciding with the 5th counting transition leaves both counters at 0.
- Saturation (ARGMAX_STATS_EN, WN=4): 17 matching vectors. Required: both counters stop at 15.

Source files
------------

// File: rtl/output_argmax_if.sv
// Stream bundle for output_argmax: vector input, class/max result and, with
// ARGMAX_STATS_EN defined, the label stream and accuracy statistics.
interface output_argmax_if #(
    parameter int NO  = 7,
    parameter int NH1 = 6,
    parameter int WV  = 8,
    parameter int WN  = 16
);
    localparam int WO = $clog2(NH1) + 1 + WV;
    localparam int WC = (NO > 1) ? $clog2(NO) : 1;

    logic               iValid_AM_Output;
    logic               oReady_AM_Output;
    logic [NO*WO-1:0]   iData_AM_Output;
    logic               oValid_BM_Class;
    logic               iReady_BM_Class;
    logic [WC-1:0]      oData_BM_Class;
    logic [WO-1:0]      oData_BM_Max;

    // Out-of-range parameters elaborate an undriven flag that lint reports.
    if (NO < 1 || WN < 1) begin : gBadParams
        logic badParams;
    end

`ifdef ARGMAX_STATS_EN
    logic               iValid_AS_Label;
    logic               oReady_AS_Label;
    logic [WC-1:0]      iData_AS_Label;
    logic               oData_BM_Hit;
    logic               iClear;
    logic [WN-1:0]      oHitCount;
    logic [WN-1:0]      oTotalCount;

    modport slave (
        input  iValid_AM_Output, iData_AM_Output, iReady_BM_Class,
               iValid_AS_Label, iData_AS_Label, iClear,
        output oReady_AM_Output, oValid_BM_Class, oData_BM_Class, oData_BM_Max,
               oReady_AS_Label, oData_BM_Hit, oHitCount, oTotalCount
    );
    modport master (
        output iValid_AM_Output, iData_AM_Output, iReady_BM_Class,
               iValid_AS_Label, iData_AS_Label, iClear,
        input  oReady_AM_Output, oValid_BM_Class, oData_BM_Class, oData_BM_Max,
               oReady_AS_Label, oData_BM_Hit, oHitCount, oTotalCount
    );
`else
    modport slave (
        input  iValid_AM_Output, iData_AM_Output, iReady_BM_Class,
        output oReady_AM_Output, oValid_BM_Class, oData_BM_Class, oData_BM_Max
    );
    modport master (
        output iValid_AM_Output, iData_AM_Output, iReady_BM_Class,
        input  oReady_AM_Output, oValid_BM_Class, oData_BM_Class, oData_BM_Max
    );
`endif
endinterface

// File: rtl/output_argmax.sv
// Serial argmax over NO signed lanes (one lane per cycle); result on a valid/ready stream.
// Define ARGMAX_STATS_EN to add the label stream and saturating hit/total counters.
module output_argmax #(
    parameter int NO  = 7,
    parameter int NH1 = 6,
    parameter int WV  = 8,
    parameter int WN  = 16
) (
    input  logic           iCLK,
    input  logic           iRST,
    output_argmax_if.slave bus
);
    localparam int WO = $clog2(NH1) + 1 + WV;
    localparam int WC = (NO > 1) ? $clog2(NO) : 1;
    localparam logic [WC-1:0] LAST_LANE = WC'(NO - 1);

    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;
    state_t state_q, state_d;

    logic signed [WO-1:0] lanes_q [NO];
    logic signed [WO-1:0] lanes_d [NO];
    logic signed [WO-1:0] max_q, max_d, resMax_q, resMax_d, laneK, srcMax;
    logic [WC-1:0]        idx_q, idx_d, k_q, k_d, resIdx_q, resIdx_d, srcIdx;
    logic                 readyInt, accept, toOut, better;

    if (NO < 1 || WN < 1) begin : gBadParams
        logic badParams;
    end

`ifdef ARGMAX_STATS_EN
    localparam logic [WN-1:0] CNT_MAX = '1;
    logic [WC-1:0] label_q, label_d, labelNow;
    logic          hit_q, hit_d, hitNow;
    logic [WN-1:0] hitCnt_q, hitCnt_d, totCnt_q, totCnt_d;

    assign accept = readyInt && bus.iValid_AM_Output && bus.iValid_AS_Label;
`else
    assign accept = readyInt && bus.iValid_AM_Output;
`endif

    assign toOut = (state_d == OUT) && (state_q != OUT);

    always_ff @(posedge iCLK) begin
        if (iRST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (NO == 1) ? OUT : SCAN;
            SCAN:    if (k_q == LAST_LANE) state_d = OUT;
            OUT:     if (bus.iReady_BM_Class) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are gated by reset so nothing is offered or accepted while it is held.
    always_comb begin
        readyInt             = (state_q == IDLE) && !iRST;
        bus.oReady_AM_Output = readyInt;
        bus.oValid_BM_Class  = (state_q == OUT) && !iRST;
        bus.oData_BM_Class   = resIdx_q;
        bus.oData_BM_Max     = resMax_q;
`ifdef ARGMAX_STATS_EN
        bus.oReady_AS_Label  = readyInt;
        bus.oData_BM_Hit     = hit_q;
        bus.oHitCount        = hitCnt_q;
        bus.oTotalCount      = totCnt_q;
`endif
    end

    // srcMax/srcIdx is the best-so-far after this cycle; in IDLE it is lane 0 of the incoming vector.
    always_comb begin
        lanes_d  = lanes_q;
        max_d    = max_q;
        idx_d    = idx_q;
        k_d      = k_q;
        resMax_d = resMax_q;
        resIdx_d = resIdx_q;
        laneK    = lanes_q[k_q];
        better   = laneK > max_q;
        if (state_q == SCAN) begin
            srcMax = better ? laneK : max_q;
            srcIdx = better ? k_q : idx_q;
        end else begin
            srcMax = $signed(bus.iData_AM_Output[WO-1:0]);
            srcIdx = '0;
        end
        if (accept) begin
            for (int k = 0; k < NO; k++) lanes_d[k] = $signed(bus.iData_AM_Output[k*WO +: WO]);
            max_d = srcMax;
            idx_d = '0;
            k_d   = WC'(1);
        end else if (state_q == SCAN) begin
            max_d = srcMax;
            idx_d = srcIdx;
            k_d   = k_q + WC'(1);
        end
        if (toOut) begin
            resMax_d = srcMax;
            resIdx_d = srcIdx;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int k = 0; k < NO; k++) lanes_q[k] <= '0;
            max_q    <= '0;
            idx_q    <= '0;
            k_q      <= '0;
            resMax_q <= '0;
            resIdx_q <= '0;
        end else begin
            lanes_q  <= lanes_d;
            max_q    <= max_d;
            idx_q    <= idx_d;
            k_q      <= k_d;
            resMax_q <= resMax_d;
            resIdx_q <= resIdx_d;
        end
    end

`ifdef ARGMAX_STATS_EN
    // A clear in the same cycle as a finished scan discards that event from the counters.
    always_comb begin
        label_d  = label_q;
        hit_d    = hit_q;
        hitCnt_d = hitCnt_q;
        totCnt_d = totCnt_q;
        labelNow = (state_q == IDLE) ? bus.iData_AS_Label : label_q;
        hitNow   = (srcIdx == labelNow);
        if (accept) label_d = bus.iData_AS_Label;
        if (toOut)  hit_d   = hitNow;
        if (bus.iClear) begin
            hitCnt_d = '0;
            totCnt_d = '0;
        end else if (toOut) begin
            if (totCnt_q != CNT_MAX)           totCnt_d = totCnt_q + WN'(1);
            if (hitNow && hitCnt_q != CNT_MAX) hitCnt_d = hitCnt_q + WN'(1);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            label_q  <= '0;
            hit_q    <= 1'b0;
            hitCnt_q <= '0;
            totCnt_q <= '0;
        end else begin
            label_q  <= label_d;
            hit_q    <= hit_d;
            hitCnt_q <= hitCnt_d;
            totCnt_q <= totCnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_output_argmax.sv
// Self-checking bench for output_argmax: directed cases plus randomized vectors
// against a behavioural argmax/counter model; stats cases run with ARGMAX_STATS_EN.
module tb_output_argmax;
    localparam int NO  = 7;
    localparam int NH1 = 6;
    localparam int WV  = 8;
`ifdef ARGMAX_STATS_EN
    localparam int WN  = 4;
`else
    localparam int WN  = 16;
`endif
    localparam int WO = $clog2(NH1) + 1 + WV;
    localparam int WC = (NO > 1) ? $clog2(NO) : 1;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
`ifdef ARGMAX_STATS_EN
    localparam int CNT_MAX = (1 << WN) - 1;
    int hitModel = 0;
    int totModel = 0;
`endif

    output_argmax_if #(.NO(NO), .NH1(NH1), .WV(WV), .WN(WN)) bus ();

    output_argmax #(.NO(NO), .NH1(NH1), .WV(WV), .WN(WN)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first lane holding the largest signed value.
    function automatic void refArgmax(input int lanes [NO], output int idx, output int mx);
        idx = 0;
        mx  = lanes[0];
        for (int k = 1; k < NO; k++)
            if (lanes[k] > mx) begin
                mx  = lanes[k];
                idx = k;
            end
    endfunction

    task automatic applyStimulus(input int lanes [NO], input int label, input int hold, input int clearAt);
        int             expIdx, expMax, cycles;
        logic [WO-1:0]  expMaxBits;
        logic           stable;
        refArgmax(lanes, expIdx, expMax);
        expMaxBits = WO'(expMax);
        cycles = 0;
        while (!bus.oReady_AM_Output && cycles < 20) begin
            tick();
            cycles++;
        end
        checkOutput("inReady", 32'(bus.oReady_AM_Output), 32'd1);
        for (int k = 0; k < NO; k++) bus.iData_AM_Output[k*WO +: WO] = WO'(lanes[k]);
        bus.iValid_AM_Output = 1'b1;
`ifdef ARGMAX_STATS_EN
        bus.iValid_AS_Label = 1'b1;
        bus.iData_AS_Label  = WC'(label);
`endif
        tick();
        for (int k = 0; k < NO; k++) bus.iData_AM_Output[k*WO +: WO] = WO'($urandom);
`ifdef ARGMAX_STATS_EN
        bus.iData_AS_Label = WC'($urandom_range(0, NO - 1));
`endif
        checkOutput("scanReadyLow", 32'(bus.oReady_AM_Output), 32'd0);
        cycles = 1;
        while (!bus.oValid_BM_Class && cycles < 50) begin
`ifdef ARGMAX_STATS_EN
            if (cycles == clearAt) bus.iClear = 1'b1;
`endif
            tick();
`ifdef ARGMAX_STATS_EN
            bus.iClear = 1'b0;
`endif
            cycles++;
        end
        bus.iValid_AM_Output = 1'b0;
`ifdef ARGMAX_STATS_EN
        bus.iValid_AS_Label = 1'b0;
`endif
        checkOutput("latency", 32'(cycles), 32'(NO));
        checkOutput("class", 32'(bus.oData_BM_Class), 32'(expIdx));
        checkOutput("max", 32'(bus.oData_BM_Max), 32'(expMaxBits));
        checkOutput("outReadyLow", 32'(bus.oReady_AM_Output), 32'd0);
`ifdef ARGMAX_STATS_EN
        if (clearAt >= 0) begin
            hitModel = 0;
            totModel = 0;
        end else begin
            if (totModel < CNT_MAX) totModel++;
            if (expIdx == label && hitModel < CNT_MAX) hitModel++;
        end
        checkOutput("hit", 32'(bus.oData_BM_Hit), 32'(expIdx == label));
        checkOutput("hitCount", 32'(bus.oHitCount), 32'(hitModel));
        checkOutput("totalCount", 32'(bus.oTotalCount), 32'(totModel));
`endif
        if (hold > 0) begin
            bus.iReady_BM_Class = 1'b0;
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                tick();
                if (!bus.oValid_BM_Class || bus.oData_BM_Class != WC'(expIdx) ||
                    bus.oData_BM_Max != expMaxBits || bus.oReady_AM_Output) stable = 1'b0;
            end
            checkOutput("holdStable", 32'(stable), 32'd1);
            bus.iReady_BM_Class = 1'b1;
        end
        tick();
        checkOutput("releasedValid", 32'(bus.oValid_BM_Class), 32'd0);
        checkOutput("idleReady", 32'(bus.oReady_AM_Output), 32'd1);
    endtask

    int   vec [NO];
    logic sawValid, readyLow;
    int   v;

    initial begin
        rst = 1'b1;
        bus.iValid_AM_Output = 1'b0;
        bus.iData_AM_Output  = '0;
        bus.iReady_BM_Class  = 1'b1;
`ifdef ARGMAX_STATS_EN
        bus.iValid_AS_Label  = 1'b0;
        bus.iData_AS_Label   = '0;
        bus.iClear           = 1'b0;
`endif
        tick();
        tick();
        checkOutput("rstReady", 32'(bus.oReady_AM_Output), 32'd0);
        checkOutput("rstValid", 32'(bus.oValid_BM_Class), 32'd0);
        checkOutput("rstClass", 32'(bus.oData_BM_Class), 32'd0);
        checkOutput("rstMax", 32'(bus.oData_BM_Max), 32'd0);
`ifdef ARGMAX_STATS_EN
        checkOutput("rstLabelReady", 32'(bus.oReady_AS_Label), 32'd0);
        checkOutput("rstHit", 32'(bus.oData_BM_Hit), 32'd0);
        checkOutput("rstHitCount", 32'(bus.oHitCount), 32'd0);
        checkOutput("rstTotalCount", 32'(bus.oTotalCount), 32'd0);
`endif
        rst = 1'b0;
        #1;
        checkOutput("releaseReady", 32'(bus.oReady_AM_Output), 32'd1);

        $display("[TB] directed vectors");
        vec = '{5, -3, 40, 12, 40, -100, 0};
        applyStimulus(vec, 2, 0, -1);
        vec = '{-2048, -7, -1, -1, -300, -5, -2047};
        applyStimulus(vec, 0, 0, -1);
        vec = '{100, 2047, -2048, 2047, 0, 1, 3};
        applyStimulus(vec, 1, 20, -1);
        vec = '{-4, -4, -4, -4, -4, -4, -4};
        applyStimulus(vec, 0, 0, -1);

        $display("[TB] randomized vectors");
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NO; k++) begin
                if (n % 2 == 1) v = int'($urandom_range(0, 3)) - 2;
                else begin
                    v = int'($urandom_range(0, 4095));
                    if (v > 2047) v = v - 4096;
                end
                vec[k] = v;
            end
            applyStimulus(vec, int'($urandom_range(0, NO - 1)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, -1);
        end

        $display("[TB] reset during scan");
        vec = '{1, 2, 3, 4, 5, 6, 7};
        for (int k = 0; k < NO; k++) bus.iData_AM_Output[k*WO +: WO] = WO'(vec[k]);
        bus.iValid_AM_Output = 1'b1;
`ifdef ARGMAX_STATS_EN
        bus.iValid_AS_Label = 1'b1;
`endif
        tick();
        bus.iValid_AM_Output = 1'b0;
`ifdef ARGMAX_STATS_EN
        bus.iValid_AS_Label = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b1;
        #1;
        sawValid = bus.oValid_BM_Class;
        readyLow = !bus.oReady_AM_Output;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.oValid_BM_Class) sawValid = 1'b1;
            if (bus.oReady_AM_Output) readyLow = 1'b0;
        end
        checkOutput("midRstReadyLow", 32'(readyLow), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("midRstReleaseReady", 32'(bus.oReady_AM_Output), 32'd1);
        for (int c = 0; c < NO + 3; c++) begin
            tick();
            if (bus.oValid_BM_Class) sawValid = 1'b1;
        end
        checkOutput("midRstNoValid", 32'(sawValid), 32'd0);
        checkOutput("midRstClass", 32'(bus.oData_BM_Class), 32'd0);
`ifdef ARGMAX_STATS_EN
        hitModel = 0;
        totModel = 0;
`endif
        vec = '{0, 0, 0, 0, 0, 0, 9};
        applyStimulus(vec, 6, 0, -1);

`ifdef ARGMAX_STATS_EN
        $display("[TB] statistics");
        bus.iClear = 1'b1;
        tick();
        bus.iClear = 1'b0;
        hitModel = 0;
        totModel = 0;
        for (int n = 0; n < 4; n++) begin
            int winners [4];
            int labels [4];
            winners = '{1, 3, 3, 0};
            labels  = '{1, 2, 3, 0};
            for (int k = 0; k < NO; k++) vec[k] = (k == winners[n]) ? 50 : -5;
            applyStimulus(vec, labels[n], 0, -1);
        end
        checkOutput("statsHitCount", 32'(bus.oHitCount), 32'd3);
        checkOutput("statsTotalCount", 32'(bus.oTotalCount), 32'd4);
        for (int k = 0; k < NO; k++) vec[k] = (k == 4) ? 9 : 0;
        applyStimulus(vec, 4, 0, NO - 1);
        checkOutput("clearHitCount", 32'(bus.oHitCount), 32'd0);
        checkOutput("clearTotalCount", 32'(bus.oTotalCount), 32'd0);
        for (int n = 0; n < 17; n++) begin
            for (int k = 0; k < NO; k++) vec[k] = (k == 2) ? 30 : -30;
            applyStimulus(vec, 2, 0, -1);
        end
        checkOutput("satHitCount", 32'(bus.oHitCount), 32'd15);
        checkOutput("satTotalCount", 32'(bus.oTotalCount), 32'd15);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
